// File: rtl/yutorina_pkg.sv
// Shared constants for the yutorina fetch path: bus widths, active-low strobe
// levels, fetch FSM state encodings and the reset defaults of the IF stage.
package yutorina_pkg;

    localparam int unsigned IF_ADDR_W = 30;
    localparam int unsigned IF_DATA_W = 32;

    // Active-low control levels used on the bus and the pipeline enables
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Fetch FSM encodings
    typedef logic [1:0] if_state_t;
    localparam if_state_t IF_IDLE   = 2'd0;
    localparam if_state_t IF_REQ    = 2'd1;
    localparam if_state_t IF_ACCESS = 2'd2;

    localparam logic [IF_ADDR_W-1:0] IF_RESET_VECTOR = '0;
    localparam logic [IF_DATA_W-1:0] IF_NOP_INSN     = '0;

endpackage

// File: rtl/yutorina_bus_if.sv
// Fetch bus master: request/grant/strobe sequencing and the drop flag that
// discards an access whose target was invalidated by a redirect.
module yutorina_bus_if
    import yutorina_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_stall,
    input  logic i_hold_v,
    input  logic i_redirect,
    input  logic i_bus_grant_,
    input  logic i_bus_rdy_,
    output logic o_bus_req_,
    output logic o_bus_as_,
    output logic o_cpl_valid
);

    if_state_t r_state;
    if_state_t w_state_next;
    logic      r_drop;
    logic      w_drop_next;
    logic      w_cpl;

    assign w_cpl       = (r_state == IF_ACCESS) && (i_bus_rdy_ == ENABLE_);
    assign o_cpl_valid = w_cpl & ~r_drop;
    assign o_bus_req_  = (r_state == IF_IDLE) ? DISABLE_ : ENABLE_;
    assign o_bus_as_   = (r_state == IF_ACCESS) ? ENABLE_ : DISABLE_;

    // Next fetch state; an undrained hold buffer under stall parks the FSM in IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IF_IDLE: begin
                if (!i_hold_v || !i_stall) begin
                    w_state_next = IF_REQ;
                end
            end
            IF_REQ: begin
                if (i_bus_grant_ == ENABLE_) begin
                    w_state_next = IF_ACCESS;
                end
            end
            IF_ACCESS: begin
                if (w_cpl) begin
                    if (i_stall || i_hold_v) begin
                        w_state_next = IF_IDLE;
                    end else if (i_bus_grant_ == ENABLE_) begin
                        w_state_next = IF_ACCESS;
                    end else begin
                        w_state_next = IF_REQ;
                    end
                end
            end
            default: w_state_next = IF_IDLE;
        endcase
    end

    // Drop marks an in-flight access made stale by a redirect; cleared when it completes
    always_comb begin
        w_drop_next = r_drop;
        if (w_cpl) begin
            w_drop_next = 1'b0;
        end else if (i_redirect && (r_state == IF_ACCESS)) begin
            w_drop_next = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IF_IDLE;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_drop  <= w_drop_next;
        end
    end

endmodule

// File: rtl/yutorina_if_stage.sv
// Instruction-fetch stage: owns the PC, a one-entry hold buffer that catches a
// fetch completing under stall, and the IF/ID pipeline registers.
module yutorina_if_stage
    import yutorina_pkg::*;
#(
    parameter int unsigned          ADDR_W       = IF_ADDR_W,
    parameter int unsigned          DATA_W       = IF_DATA_W,
    parameter logic [ADDR_W-1:0]    RESET_VECTOR = IF_RESET_VECTOR,
    parameter logic [DATA_W-1:0]    NOP_INSN     = IF_NOP_INSN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_new_pc,
    input  logic              i_br_taken,
    input  logic [ADDR_W-1:0] i_br_addr,
    output logic              o_bus_req_,
    input  logic              i_bus_grant_,
    output logic              o_bus_as_,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic              o_bus_rw,
    input  logic [DATA_W-1:0] i_bus_rd_data,
    input  logic              i_bus_rdy_,
    output logic              o_if_en_,
    output logic [ADDR_W-1:0] o_if_pc,
    output logic [DATA_W-1:0] o_if_insn
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_hold_v;
    logic [ADDR_W-1:0] r_hold_pc;
    logic [DATA_W-1:0] r_hold_insn;
    logic              r_if_en_;
    logic [ADDR_W-1:0] r_if_pc;
    logic [DATA_W-1:0] r_if_insn;

    logic [ADDR_W-1:0] w_pc_next;
    logic              w_hold_v_next;
    logic [ADDR_W-1:0] w_hold_pc_next;
    logic [DATA_W-1:0] w_hold_insn_next;
    logic              w_if_en_next;
    logic [ADDR_W-1:0] w_if_pc_next;
    logic [DATA_W-1:0] w_if_insn_next;

    logic              w_redirect;
    logic              w_cpl_valid;

    // A branch is only honoured when not stalled; flush always is
    assign w_redirect = i_flush | (i_br_taken & ~i_stall);

    yutorina_bus_if u_bus_if (
        .clk          (clk),
        .rst          (rst),
        .i_stall      (i_stall),
        .i_hold_v     (r_hold_v),
        .i_redirect   (w_redirect),
        .i_bus_grant_ (i_bus_grant_),
        .i_bus_rdy_   (i_bus_rdy_),
        .o_bus_req_   (o_bus_req_),
        .o_bus_as_    (o_bus_as_),
        .o_cpl_valid  (w_cpl_valid)
    );

    assign o_bus_addr = r_pc;
    assign o_bus_rw   = READ;
    assign o_if_en_   = r_if_en_;
    assign o_if_pc    = r_if_pc;
    assign o_if_insn  = r_if_insn;

    // PC, hold buffer and output register update; priority flush > stall > branch
    always_comb begin
        w_pc_next        = r_pc;
        w_hold_v_next    = r_hold_v;
        w_hold_pc_next   = r_hold_pc;
        w_hold_insn_next = r_hold_insn;
        w_if_en_next     = r_if_en_;
        w_if_pc_next     = r_if_pc;
        w_if_insn_next   = r_if_insn;
        if (i_flush) begin
            w_pc_next      = i_new_pc;
            w_hold_v_next  = 1'b0;
            w_if_en_next   = DISABLE_;
            w_if_insn_next = NOP_INSN;
        end else if (i_stall) begin
            // Outputs frozen; a completing fetch is parked rather than lost
            if (w_cpl_valid) begin
                w_hold_insn_next = i_bus_rd_data;
                w_hold_pc_next   = r_pc;
                w_hold_v_next    = 1'b1;
                w_pc_next        = r_pc + ADDR_W'(1);
            end
        end else if (i_br_taken) begin
            // No delay slot: whatever completes now is squashed
            w_pc_next      = i_br_addr;
            w_hold_v_next  = 1'b0;
            w_if_en_next   = DISABLE_;
            w_if_insn_next = NOP_INSN;
        end else if (r_hold_v) begin
            w_if_en_next   = ENABLE_;
            w_if_pc_next   = r_hold_pc;
            w_if_insn_next = r_hold_insn;
            w_hold_v_next  = 1'b0;
        end else if (w_cpl_valid) begin
            w_if_en_next   = ENABLE_;
            w_if_pc_next   = r_pc;
            w_if_insn_next = i_bus_rd_data;
            w_pc_next      = r_pc + ADDR_W'(1);
        end else begin
            w_if_en_next   = DISABLE_;
            w_if_pc_next   = r_pc;
            w_if_insn_next = NOP_INSN;
        end
    end

    // Stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_VECTOR;
            r_hold_v    <= 1'b0;
            r_hold_pc   <= RESET_VECTOR;
            r_hold_insn <= NOP_INSN;
            r_if_en_    <= DISABLE_;
            r_if_pc     <= RESET_VECTOR;
            r_if_insn   <= NOP_INSN;
        end else begin
            r_pc        <= w_pc_next;
            r_hold_v    <= w_hold_v_next;
            r_hold_pc   <= w_hold_pc_next;
            r_hold_insn <= w_hold_insn_next;
            r_if_en_    <= w_if_en_next;
            r_if_pc     <= w_if_pc_next;
            r_if_insn   <= w_if_insn_next;
        end
    end

endmodule

// File: tb/tb_yutorina_if_stage.sv
// Bench for yutorina_if_stage: a memory responder with mem[a] = a + 100, a
// program-order model of which PC must be delivered next, and directed vectors.
module tb_yutorina_if_stage;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          br_taken = 1'b0;
    logic [AW-1:0] new_pc = '0;
    logic [AW-1:0] br_addr = '0;

    logic          bus_req_n;
    logic          bus_grant_n;
    logic          bus_as_n;
    logic [AW-1:0] bus_addr;
    logic          bus_rw;
    logic [DW-1:0] bus_rd_data;
    logic          bus_rdy_n;
    logic          if_en_n;
    logic [AW-1:0] if_pc;
    logic [DW-1:0] if_insn;

    // 0: zero-wait, grant/rdy held low. 1: two wait states, grant dropped at completion.
    int mode = 0;
    int ws_cnt = 0;

    int n_checks = 0;
    int n_fail = 0;
    int n_deliv = 0;

    always #5 clk = ~clk;

    yutorina_if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_new_pc      (new_pc),
        .i_br_taken    (br_taken),
        .i_br_addr     (br_addr),
        .o_bus_req_    (bus_req_n),
        .i_bus_grant_  (bus_grant_n),
        .o_bus_as_     (bus_as_n),
        .o_bus_addr    (bus_addr),
        .o_bus_rw      (bus_rw),
        .i_bus_rd_data (bus_rd_data),
        .i_bus_rdy_    (bus_rdy_n),
        .o_if_en_      (if_en_n),
        .o_if_pc       (if_pc),
        .o_if_insn     (if_insn)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'(a) + 32'd100;
    endfunction

    always_comb begin
        if (mode == 0) begin
            bus_rdy_n = 1'b0;
        end else begin
            bus_rdy_n = (bus_as_n == 1'b0 && ws_cnt >= 2) ? 1'b0 : 1'b1;
        end
        bus_grant_n = (mode == 1 && bus_as_n == 1'b0 && bus_rdy_n == 1'b0) ? 1'b1 : 1'b0;
        bus_rd_data = mem_word(bus_addr);
    end

    always @(posedge clk) begin
        if (bus_as_n == 1'b0 && bus_rdy_n == 1'b1) ws_cnt <= ws_cnt + 1;
        else ws_cnt <= 0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Program-order model: next PC to be delivered, redirected by flush/branch
    logic [AW-1:0] m_next_pc = '0;
    logic          p_en = 1'b1;
    logic [AW-1:0] p_pc = '0;
    logic [DW-1:0] p_insn = '0;

    always @(posedge clk) begin : cmp
        logic          s_rst, s_stall, s_flush, s_br, s_as, s_rdy;
        logic [AW-1:0] s_new, s_br_addr;
        s_rst = rst;
        s_stall = stall;
        s_flush = flush;
        s_br = br_taken;
        s_new = new_pc;
        s_br_addr = br_addr;
        s_as = bus_as_n;
        s_rdy = bus_rdy_n;
        #1;
        check("bus_rw", 64'(bus_rw), 64'd1);
        if (bus_as_n == 1'b0) check("req_during_as", 64'(bus_req_n), 64'd0);
        if (s_rst) begin
            check("rst_if_en", 64'(if_en_n), 64'd1);
            check("rst_if_pc", 64'(if_pc), 64'd0);
            check("rst_if_insn", 64'(if_insn), 64'd0);
            check("rst_bus_req", 64'(bus_req_n), 64'd1);
            check("rst_bus_as", 64'(bus_as_n), 64'd1);
            m_next_pc = '0;
        end else begin
            if (s_as == 1'b0 && s_rdy == 1'b1) check("as_held", 64'(bus_as_n), 64'd0);
            if (s_stall && !s_flush) begin
                check("stall_en", 64'(if_en_n), 64'(p_en));
                check("stall_pc", 64'(if_pc), 64'(p_pc));
                check("stall_insn", 64'(if_insn), 64'(p_insn));
            end else if (s_flush || s_br) begin
                check("redirect_bubble", 64'(if_en_n), 64'd1);
                m_next_pc = s_flush ? s_new : s_br_addr;
            end else if (if_en_n == 1'b0) begin
                check("deliv_pc", 64'(if_pc), 64'(m_next_pc));
                check("deliv_insn", 64'(if_insn), 64'(mem_word(m_next_pc)));
                m_next_pc = m_next_pc + 30'd1;
                n_deliv++;
            end
        end
        p_en = if_en_n;
        p_pc = if_pc;
        p_insn = if_insn;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset values and first-fetch latency
        rst = 1'b1;
        step();
        step();
        check("t1_rst_en", 64'(if_en_n), 64'd1);
        check("t1_rst_req", 64'(bus_req_n), 64'd1);
        rst = 1'b0;
        step();
        check("t1_lat1", 64'(if_en_n), 64'd1);
        step();
        check("t1_lat2", 64'(if_en_n), 64'd1);
        step();
        check("t1_first_en", 64'(if_en_n), 64'd0);
        check("t1_first_pc", 64'(if_pc), 64'd0);
        check("t1_first_insn", 64'(if_insn), 64'd100);
        repeat (4) step();
        check("t1_pc4", 64'(if_pc), 64'd4);
        check("t1_insn4", 64'(if_insn), 64'd104);

        // Stall while the fetch of pc=5 completes
        stall = 1'b1;
        repeat (3) step();
        check("t2_frozen_en", 64'(if_en_n), 64'd0);
        check("t2_frozen_pc", 64'(if_pc), 64'd4);
        check("t2_frozen_insn", 64'(if_insn), 64'd104);
        stall = 1'b0;
        step();
        check("t2_hold_pc", 64'(if_pc), 64'd5);
        check("t2_hold_insn", 64'(if_insn), 64'd105);
        step();
        check("t2_restart_bubble", 64'(if_en_n), 64'd1);
        step();
        check("t2_pc6", 64'(if_pc), 64'd6);
        check("t2_insn6", 64'(if_insn), 64'd106);
        step();
        check("t2_pc7", 64'(if_pc), 64'd7);

        // Branch while pc=8 is in flight
        br_taken = 1'b1;
        br_addr = 30'h40;
        step();
        br_taken = 1'b0;
        check("t3_squash", 64'(if_en_n), 64'd1);
        step();
        check("t3_target_en", 64'(if_en_n), 64'd0);
        check("t3_target_pc", 64'(if_pc), 64'h40);
        check("t3_target_insn", 64'(if_insn), 64'd164);
        step();

        // Flush and branch together: flush wins
        flush = 1'b1;
        new_pc = 30'h100;
        br_taken = 1'b1;
        br_addr = 30'h40;
        step();
        flush = 1'b0;
        br_taken = 1'b0;
        check("t4_bubble", 64'(if_en_n), 64'd1);
        step();
        check("t4_pc", 64'(if_pc), 64'h100);
        check("t4_insn", 64'(if_insn), 64'd356);

        // Two wait states, grant withdrawn at each completion
        mode = 1;
        step();
        check("t5_wait1_en", 64'(if_en_n), 64'd1);
        check("t5_wait1_as", 64'(bus_as_n), 64'd0);
        step();
        check("t5_wait2_as", 64'(bus_as_n), 64'd0);
        step();
        check("t5_pc101", 64'(if_pc), 64'h101);
        check("t5_insn101", 64'(if_insn), 64'd357);
        check("t5_req_state_req", 64'(bus_req_n), 64'd0);
        check("t5_req_state_as", 64'(bus_as_n), 64'd1);
        repeat (3) step();
        check("t5_gap_bubble", 64'(if_en_n), 64'd1);
        step();
        check("t5_pc102", 64'(if_pc), 64'h102);
        repeat (4) step();
        check("t5_pc103", 64'(if_pc), 64'h103);
        check("t5_insn103", 64'(if_insn), 64'd359);
        step();
        step();

        // Reset in the middle of a pending access
        rst = 1'b1;
        step();
        check("t6_rst_en", 64'(if_en_n), 64'd1);
        check("t6_rst_as", 64'(bus_as_n), 64'd1);
        check("t6_rst_pc", 64'(if_pc), 64'd0);
        rst = 1'b0;
        mode = 0;
        step();
        check("t6_lat1", 64'(if_en_n), 64'd1);
        step();
        check("t6_lat2", 64'(if_en_n), 64'd1);
        step();
        check("t6_pc0", 64'(if_pc), 64'd0);
        check("t6_insn0", 64'(if_insn), 64'd100);
        step();
        check("t6_pc1", 64'(if_pc), 64'd1);
        check("deliv_total", 64'(n_deliv), 64'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
